hazard_controller: RTL



---
 rtl/hazard_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// Tracks EX/MEM/WB occupancy and drives stall, flush, freeze and forwarding selects.
module hazard_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_mem_write,
  input  logic       ex_branch_taken,
  input  logic       dmem_ready,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       freeze,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  logic       r_ex_valid;
  logic [4:0] r_ex_rs1;
  logic [4:0] r_ex_rs2;
  logic       r_ex_uses_rs1;
  logic       r_ex_uses_rs2;
  logic [4:0] r_ex_rd;
  logic       r_ex_reg_write;
  logic       r_ex_mem_read;
  logic       r_ex_mem_access;

  logic       r_mem_valid;
  logic [4:0] r_mem_rd;
  logic       r_mem_reg_write;
  logic       r_mem_mem_access;

  logic       r_wb_valid;
  logic [4:0] r_wb_rd;
  logic       r_wb_reg_write;

  logic       w_mem_wait;
  logic       w_load_use;
  logic       w_branch;
  logic       w_load_use_stall;

  // Youngest producer wins: MEM is checked before WB, and x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic       ex_valid,
    input logic       uses,
    input logic [4:0] rs,
    input logic       mem_valid,
    input logic       mem_rw,
    input logic [4:0] mem_rd,
    input logic       wb_valid,
    input logic       wb_rw,
    input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_valid && uses && mem_valid && mem_rw && (mem_rd != 5'd0) && (mem_rd == rs))
      sel = FWD_MEM;
    else if (ex_valid && uses && wb_valid && wb_rw && (wb_rd != 5'd0) && (wb_rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

  assign w_mem_wait = r_mem_valid & r_mem_mem_access & ~dmem_ready;

  assign w_load_use = id_valid & r_ex_valid & r_ex_mem_read & r_ex_reg_write &
                      (r_ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == r_ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == r_ex_rd)));

  // Freeze outranks a branch, which in turn discards any load-use in ID.
  assign w_branch         = ex_branch_taken & ~reset & ~w_mem_wait;
  assign w_load_use_stall = w_load_use & ~w_mem_wait & ~ex_branch_taken;

  assign freeze   = w_mem_wait;
  assign stall_if = w_mem_wait | w_load_use_stall;
  assign stall_id = w_mem_wait | w_load_use_stall;
  assign flush_id = w_branch;
  assign flush_ex = w_branch | w_load_use_stall;

  assign forward_a = fwd_sel(r_ex_valid, r_ex_uses_rs1, r_ex_rs1,
                             r_mem_valid, r_mem_reg_write, r_mem_rd,
                             r_wb_valid, r_wb_reg_write, r_wb_rd);
  assign forward_b = fwd_sel(r_ex_valid, r_ex_uses_rs2, r_ex_rs2,
                             r_mem_valid, r_mem_reg_write, r_mem_rd,
                             r_wb_valid, r_wb_reg_write, r_wb_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid       <= 1'b0;
      r_ex_rs1         <= 5'd0;
      r_ex_rs2         <= 5'd0;
      r_ex_uses_rs1    <= 1'b0;
      r_ex_uses_rs2    <= 1'b0;
      r_ex_rd          <= 5'd0;
      r_ex_reg_write   <= 1'b0;
      r_ex_mem_read    <= 1'b0;
      r_ex_mem_access  <= 1'b0;
      r_mem_valid      <= 1'b0;
      r_mem_rd         <= 5'd0;
      r_mem_reg_write  <= 1'b0;
      r_mem_mem_access <= 1'b0;
      r_wb_valid       <= 1'b0;
      r_wb_rd          <= 5'd0;
      r_wb_reg_write   <= 1'b0;
    end else if (!w_mem_wait) begin
      r_wb_valid       <= r_mem_valid;
      r_wb_rd          <= r_mem_rd;
      r_wb_reg_write   <= r_mem_reg_write;
      r_mem_valid      <= r_ex_valid;
      r_mem_rd         <= r_ex_rd;
      r_mem_reg_write  <= r_ex_reg_write;
      r_mem_mem_access <= r_ex_mem_access;
      // A flushed slot keeps the ID fields but is marked invalid, so it is inert.
      r_ex_valid       <= id_valid & ~flush_ex;
      r_ex_rs1         <= id_rs1;
      r_ex_rs2         <= id_rs2;
      r_ex_uses_rs1    <= id_uses_rs1;
      r_ex_uses_rs2    <= id_uses_rs2;
      r_ex_rd          <= id_rd;
      r_ex_reg_write   <= id_reg_write;
      r_ex_mem_read    <= id_mem_read;
      r_ex_mem_access  <= id_mem_read | id_mem_write;
    end
  end

endmodule
